// File: rtl/eth_mii_tx_pkg.sv
// Shared definitions for the MII nibble transmitter: FSM state encoding,
// line nibbles for preamble/SFD and the IEEE 802.3 CRC-32 constants.
// Optional feature macro: ETH_MII_TX_CRC_EN (padding + FCS generation).
package eth_mii_tx_pkg;

  typedef enum logic [3:0] {
    IDLE,
    PRE,
    SFD,
    DLO,
    DHI,
    PAD,
    FCS,
    IFG,
    DRAIN
  } state_t;

  localparam logic [3:0]  PRE_NIB     = 4'h5;
  localparam logic [3:0]  SFD_NIB     = 4'hD;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  // Running (non-inverted) register value after data plus a correct FCS.
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

endpackage

// File: rtl/eth_crc32_nib.sv
// Combinational one-nibble step of the reflected IEEE 802.3 CRC-32.
// The nibble is consumed LSB first, matching MII bit order on the wire,
// so the receive-side checker can reuse this block unchanged.
module eth_crc32_nib
  import eth_mii_tx_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [3:0]  nib,
  output logic [31:0] crc_next
);

  function automatic logic [31:0] next_crc(input logic [31:0] c, input logic [3:0] n);
    logic [31:0] r;
    r = c ^ {28'h0, n};
    for (int i = 0; i < 4; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  assign crc_next = next_crc(crc, nib);

endmodule

// File: rtl/eth_mii_tx.sv
// MII transmitter: byte stream in, preamble/SFD/payload[/pad/FCS] out as
// registered nibbles, followed by the inter-frame gap.
// Optional feature macro: ETH_MII_TX_CRC_EN. When defined, short frames are
// zero-padded to MIN_FRAME bytes and the FCS is appended; when undefined the
// producer must supply the FCS as part of the payload.
module eth_mii_tx
  import eth_mii_tx_pkg::*;
#(
  parameter int IFG_CYCLES = 24,
  parameter int MIN_FRAME  = 60
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic [3:0] TX_DATA,
  output logic       TX_EN,
  output logic       frame_done,
  output logic       underrun,
  output logic       busy
);

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg;          // per-state cycle counter, cleared on every state change
  logic [7:0]  byte_reg;
  logic        last_taken_reg;
  logic        aborted_reg;
  logic        done_d1_reg;
  logic        frame_done_reg;
  logic        underrun_reg;
  logic        tx_en_reg;
  logic [3:0]  tx_data_reg;

  logic        ready_c;
  logic        accept;
  logic        ur_c;
  logic        en_c;
  logic [3:0]  nib_c;

`ifdef ETH_MII_TX_CRC_EN
  logic [31:0] crc_reg;
  logic [31:0] crc_next;
  logic [31:0] fcs_shift;
  logic [10:0] byte_cnt_reg;
  logic        pad_phase_reg;

  // FCS is the complemented CRC, sent low nibble first.
  assign fcs_shift = (~crc_reg) >> {cnt_reg[2:0], 2'b00};

  eth_crc32_nib u_crc (
    .crc      (crc_reg),
    .nib      (nib_c),
    .crc_next (crc_next)
  );
`endif

  // Next-state, ready and line nibble for the current state; an underrun
  // overrides everything so the line drops on the very next edge.
  always_comb begin
    state_next = state_reg;
    ready_c    = 1'b0;
    ur_c       = 1'b0;
    en_c       = 1'b0;
    nib_c      = 4'h0;
    case (state_reg)
      IDLE: begin
        if (in_valid) state_next = PRE;
      end
      PRE: begin
        en_c  = 1'b1;
        nib_c = PRE_NIB;
        if (cnt_reg == 8'd14) state_next = SFD;
      end
      SFD: begin
        en_c    = 1'b1;
        nib_c   = SFD_NIB;
        ready_c = 1'b1;
        if (in_valid) state_next = DLO;
        else          ur_c       = 1'b1;
      end
      DLO: begin
        en_c       = 1'b1;
        nib_c      = byte_reg[3:0];
        state_next = DHI;
      end
      DHI: begin
        en_c    = 1'b1;
        nib_c   = byte_reg[7:4];
        ready_c = !last_taken_reg;
        if (!last_taken_reg) begin
          if (in_valid) state_next = DLO;
          else          ur_c       = 1'b1;
        end else begin
`ifdef ETH_MII_TX_CRC_EN
          state_next = (byte_cnt_reg < 11'(MIN_FRAME)) ? PAD : FCS;
`else
          state_next = IFG;
`endif
        end
      end
`ifdef ETH_MII_TX_CRC_EN
      PAD: begin
        en_c  = 1'b1;
        nib_c = 4'h0;
        if (pad_phase_reg && (byte_cnt_reg == 11'(MIN_FRAME - 1))) state_next = FCS;
      end
      FCS: begin
        en_c  = 1'b1;
        nib_c = fcs_shift[3:0];
        if (cnt_reg == 8'd7) state_next = IFG;
      end
`endif
      IFG: begin
        if (cnt_reg == 8'(IFG_CYCLES - 1)) state_next = IDLE;
      end
      DRAIN: begin
        ready_c = 1'b1;
        if (in_valid && in_last) state_next = IFG;
      end
      default: state_next = IDLE;
    endcase
    if (ur_c) begin
      state_next = DRAIN;
      en_c       = 1'b0;
      nib_c      = 4'h0;
    end
  end

  assign accept = ready_c && in_valid;

  // State register and per-state cycle counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= (state_next != state_reg) ? 8'd0 : cnt_reg + 8'd1;
    end
  end

  // Byte capture plus per-frame flags (last byte seen, frame aborted).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      byte_reg       <= 8'h00;
      last_taken_reg <= 1'b0;
      aborted_reg    <= 1'b0;
    end else begin
      if (accept) byte_reg <= in_data;
      if (state_reg == IDLE)       last_taken_reg <= 1'b0;
      else if (accept && in_last)  last_taken_reg <= 1'b1;
      if (state_reg == IDLE)       aborted_reg <= 1'b0;
      else if (ur_c)               aborted_reg <= 1'b1;
    end
  end

  // Registered MII pins and status pulses; frame_done is delayed one extra
  // cycle so it lines up with the end of the gap as seen on the pins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_en_reg      <= 1'b0;
      tx_data_reg    <= 4'h0;
      underrun_reg   <= 1'b0;
      done_d1_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      tx_en_reg      <= en_c;
      tx_data_reg    <= en_c ? nib_c : 4'h0;
      underrun_reg   <= ur_c;
      done_d1_reg    <= (state_reg == IFG) && (state_next == IDLE) && !aborted_reg;
      frame_done_reg <= done_d1_reg;
    end
  end

`ifdef ETH_MII_TX_CRC_EN
  // CRC accumulation over payload and pad nibbles, plus the saturating
  // payload byte count that decides how much padding is needed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      crc_reg       <= CRC_INIT;
      byte_cnt_reg  <= 11'd0;
      pad_phase_reg <= 1'b0;
    end else begin
      if (state_reg == SFD)
        crc_reg <= CRC_INIT;
      else if (state_reg == DLO || state_reg == DHI || state_reg == PAD)
        crc_reg <= crc_next;

      if (state_reg == IDLE)
        byte_cnt_reg <= 11'd0;
      else if (byte_cnt_reg != 11'h7FF &&
               (((state_reg == SFD || state_reg == DHI) && accept) ||
                (state_reg == PAD && pad_phase_reg)))
        byte_cnt_reg <= byte_cnt_reg + 11'd1;

      pad_phase_reg <= (state_reg == PAD) ? !pad_phase_reg : 1'b0;
    end
  end
`endif

  assign in_ready   = ready_c;
  assign busy       = (state_reg != IDLE);
  assign TX_EN      = tx_en_reg;
  assign TX_DATA    = tx_data_reg;
  assign frame_done = frame_done_reg;
  assign underrun   = underrun_reg;

endmodule

// File: tb/tb_eth_mii_tx.sv
// Directed testbench for eth_mii_tx. Works for both builds: with
// ETH_MII_TX_CRC_EN it checks padding and the FCS residue, without it it
// checks the plain nibble stream.
module tb_eth_mii_tx;
  import eth_mii_tx_pkg::*;

  localparam int IFG_CYCLES = 24;
  localparam int MIN_FRAME  = 60;
`ifdef ETH_MII_TX_CRC_EN
  localparam bit HAS_CRC = 1'b1;
  localparam int PAD_TO  = MIN_FRAME;
  localparam int SHORT_N = 14;
`else
  localparam bit HAS_CRC = 1'b0;
  localparam int PAD_TO  = 0;
  localparam int SHORT_N = 5;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic [3:0] TX_DATA;
  logic       TX_EN;
  logic       frame_done;
  logic       underrun;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] payload [0:127];

  eth_mii_tx #(.IFG_CYCLES(IFG_CYCLES), .MIN_FRAME(MIN_FRAME)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .TX_DATA    (TX_DATA),
    .TX_EN      (TX_EN),
    .frame_done (frame_done),
    .underrun   (underrun),
    .busy       (busy)
  );

  always #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: captures nibbles while TX_EN is high and time-stamps events.
  logic [3:0] cap [$];
  int  rise_cyc = -1, fall_cyc = -1, last_gap = -1;
  int  done_cnt = 0, done_cyc = -1, ur_cnt = 0, ur_seen_cyc = -1;
  logic en_prev = 1'b0;
  always @(negedge clk) begin
    if (TX_EN) cap.push_back(TX_DATA);
    if (TX_EN && !en_prev) begin
      if (fall_cyc >= 0) last_gap = cyc - fall_cyc;
      rise_cyc = cyc;
    end
    if (!TX_EN && en_prev) fall_cyc = cyc;
    if (frame_done) begin done_cnt++; done_cyc = cyc; end
    if (underrun)   begin ur_cnt++; ur_seen_cyc = cyc; end
    en_prev = TX_EN;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Streams payload[0..n-1]; in_valid is held low for two cycles when byte
  // index drop_at is next, which guarantees a DHI with in_ready high.
  task automatic send_frame(input int n, input int drop_at, input bit keep,
                            output int start_cyc, output int ur_cyc);
    int idx = 0, gap = 0, guard = 0;
    bit take;
    start_cyc = -1;
    ur_cyc    = -1;
    while (idx < n && guard < 4000) begin
      @(negedge clk);
      guard++;
      in_data = payload[idx];
      in_last = (idx == n - 1);
      if (idx == drop_at && gap < 2) begin in_valid = 1'b0; gap++; end
      else in_valid = 1'b1;
      if (start_cyc < 0 && in_valid) start_cyc = cyc;
      #1;
      if (!in_valid && in_ready && ur_cyc < 0) ur_cyc = cyc;
      take = in_valid && in_ready;
      @(posedge clk);
      if (take) idx++;
    end
    check("send_complete", idx, n);
    if (!keep) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    int g = 0;
    do begin @(negedge clk); g++; end while (busy && g < 3000);
    check(tag, busy, 1'b0);
    repeat (4) @(negedge clk);
  endtask

  // Compares captured nibbles from index base against preamble, SFD,
  // payload and zero pad; with CRC, also checks the residue over data+FCS.
  task automatic check_frame(input string tag, input int base, input int n);
    int nb, exp_len, got_len, nerr, lim, j;
    logic [3:0] e;
    logic [7:0] b, by;
    logic [31:0] crc;
    nb      = (n < PAD_TO) ? PAD_TO : n;
    exp_len = 16 + 2 * nb + (HAS_CRC ? 8 : 0);
    got_len = cap.size() - base;
    check({tag, "_len"}, got_len, exp_len);
    nerr = 0;
    lim  = (got_len < 16 + 2 * nb) ? got_len : 16 + 2 * nb;
    for (int k = 0; k < lim; k++) begin
      if (k < 15)       e = 4'h5;
      else if (k == 15) e = 4'hD;
      else begin
        j = (k - 16) / 2;
        b = (j < n) ? payload[j] : 8'h00;
        e = ((k % 2) == 0) ? b[3:0] : b[7:4];
      end
      if (cap[base + k] !== e) nerr++;
    end
    check({tag, "_nibbles"}, nerr, 0);
    if (HAS_CRC) begin
      crc = 32'hFFFFFFFF;
      for (int m = 0; m < nb + 4; m++) begin
        if (16 + 2 * m + 1 < got_len) begin
          by = {cap[base + 16 + 2 * m + 1], cap[base + 16 + 2 * m]};
          crc = crc ^ {24'h0, by};
          for (int s = 0; s < 8; s++)
            crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
        end
      end
      check({tag, "_residue"}, crc, CRC_RESIDUE);
    end
  endtask

  initial begin
    int base, st, urc, d0, u0, f0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx_en", TX_EN, 1'b0);
    check("rst_tx_data", TX_DATA, 4'h0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Short frame: payload 1,2,3,...
    for (int i = 0; i < 128; i++) payload[i] = 8'(i + 1);
    base = cap.size(); d0 = done_cnt; u0 = ur_cnt;
    send_frame(SHORT_N, -1, 1'b0, st, urc);
    wait_idle("short_idle");
    check_frame("short", base, SHORT_N);
    check("short_latency", rise_cyc - st, 2);
    check("short_done_cnt", done_cnt - d0, 1);
    check("short_done_delay", done_cyc - fall_cyc, IFG_CYCLES);
    check("short_no_underrun", ur_cnt - u0, 0);

    // 64-byte frame
    for (int i = 0; i < 128; i++) payload[i] = 8'((i * 37 + 11) & 8'hFF);
    base = cap.size(); d0 = done_cnt;
    send_frame(64, -1, 1'b0, st, urc);
    wait_idle("long_idle");
    check_frame("long", base, 64);
    check("long_done_cnt", done_cnt - d0, 1);
    check("long_done_delay", done_cyc - fall_cyc, IFG_CYCLES);

    // Underrun before byte 10, remaining bytes drained
    base = cap.size(); d0 = done_cnt; u0 = ur_cnt;
    send_frame(20, 9, 1'b0, st, urc);
    wait_idle("ur_idle");
    check("ur_pulse_cnt", ur_cnt - u0, 1);
    check("ur_pulse_time", ur_seen_cyc - urc, 1);
    check("ur_txen_fall", fall_cyc - urc, 1);
    check("ur_txen_cycles", cap.size() - base, 33);
    check("ur_no_done", done_cnt - d0, 0);

    // Clean frame after the aborted one
    for (int i = 0; i < 128; i++) payload[i] = 8'(i + 1);
    base = cap.size(); d0 = done_cnt;
    send_frame(SHORT_N, -1, 1'b0, st, urc);
    wait_idle("post_ur_idle");
    check_frame("post_ur", base, SHORT_N);
    check("post_ur_done", done_cnt - d0, 1);

    // Back-to-back frames with in_valid continuously high
    base = cap.size(); d0 = done_cnt;
    send_frame(10, -1, 1'b1, st, urc);
    send_frame(10, -1, 1'b0, st, urc);
    wait_idle("b2b_idle");
    check("b2b_gap", last_gap, IFG_CYCLES + 1);
    check("b2b_done_cnt", done_cnt - d0, 2);
    check("b2b_total_len", cap.size() - base, 2 * (16 + 2 * ((10 < PAD_TO) ? PAD_TO : 10) + (HAS_CRC ? 8 : 0)));

    // Asynchronous reset in the middle of a frame (inside FCS with CRC)
    for (int i = 0; i < 128; i++) payload[i] = 8'((i * 13 + 5) & 8'hFF);
    d0 = done_cnt;
    send_frame(64, -1, 1'b0, st, urc);
    repeat (HAS_CRC ? 3 : 1) @(posedge clk);
    #5;
    check("mid_txen_before_rst", TX_EN, 1'b1);
    resetn = 1'b0;
    #1;
    check("mid_rst_tx_en", TX_EN, 1'b0);
    check("mid_rst_tx_data", TX_DATA, 4'h0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b0);
    check("mid_rst_frame_done", frame_done, 1'b0);
    check("mid_rst_underrun", underrun, 1'b0);
    @(posedge clk);
    #5;
    resetn = 1'b1;
    f0 = cap.size();
    repeat (40) @(negedge clk);
    check("mid_rst_no_done", done_cnt - d0, 0);
    check("mid_rst_line_quiet", cap.size() - f0, 0);

    // Frame after reset must be complete and correct
    for (int i = 0; i < 128; i++) payload[i] = 8'(i + 1);
    base = cap.size(); d0 = done_cnt;
    send_frame(SHORT_N, -1, 1'b0, st, urc);
    wait_idle("post_rst_idle");
    check_frame("post_rst", base, SHORT_N);
    check("post_rst_done", done_cnt - d0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
